// File: rtl/nco_freq_meter_if.sv
// rtl/nco_freq_meter_if.sv - sample stream in, phase-increment estimate and status out
interface nco_freq_meter_if #(
    parameter int SAMPLE_W = 12,
    parameter int PHASE_W  = 20
);
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] sample_i;
    logic [PHASE_W-1:0]         phi_est_o;
    logic                       est_valid;
    logic                       busy;
    logic                       no_signal;

    modport master (
        output in_valid, sample_i,
        input  phi_est_o, est_valid, busy, no_signal
    );

    modport slave (
        input  in_valid, sample_i,
        output phi_est_o, est_valid, busy, no_signal
    );
endinterface

// File: rtl/nco_freq_meter.sv
// rtl/nco_freq_meter.sv - zero-crossing frequency meter reporting an NCO phase increment
module nco_freq_meter #(
    parameter int SAMPLE_W = 12,
    parameter int PHASE_W  = 20,
    parameter int PERIODS  = 8,
    parameter int HYST     = 64,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    nco_freq_meter_if.slave  bus
);
    localparam int XCNT_W = $clog2(PERIODS) + 1;
    localparam int STEP_W = $clog2(PHASE_W + 1);
    localparam int DIV_W  = CNT_W + 1;

    localparam logic [1:0] ST_ARM    = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_DIVIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic signed [SAMPLE_W-1:0] NEG_HYST = SAMPLE_W'(-HYST);

    logic [1:0]         state_q, state_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XCNT_W-1:0]  xcnt_q, xcnt_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;
    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [PHASE_W-1:0] quo_q, quo_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [PHASE_W-1:0] phi_q, phi_d;
    logic               est_valid_q, est_valid_d;
    logic               no_signal_q, no_signal_d;

    logic signed [SAMPLE_W-1:0] smp;
    logic               accepted;
    logic               samples_live;
    logic               is_neg;
    logic               is_pos;
    logic               crossing;
    logic               last_cross;
    logic               cnt_full;
    logic [DIV_W:0]     rem_shift;
    logic [DIV_W:0]     rem_sub;

    assign smp          = bus.sample_i;
    assign accepted     = clken & bus.in_valid;
    assign samples_live = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign is_neg       = smp < NEG_HYST;
    assign is_pos       = ~smp[SAMPLE_W-1];
    assign crossing     = accepted & samples_live & armed_q & is_pos;
    assign last_cross   = crossing && (state_q == ST_COUNT) &&
                          (xcnt_q == XCNT_W'(PERIODS - 1));
    assign cnt_full     = &cnt_q;

    // Low dividend bits are all zero, so the partial remainder starts at PERIODS
    // and each step just shifts in a zero.
    assign rem_shift = {rem_q, 1'b0};
    assign rem_sub   = rem_shift - {1'b0, divisor_q};

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        xcnt_d      = xcnt_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        phi_d       = phi_q;
        est_valid_d = 1'b0;
        no_signal_d = no_signal_q;

        if (samples_live && accepted) begin
            if (crossing) begin
                armed_d = 1'b0;
            end else if (is_neg) begin
                armed_d = 1'b1;
            end
        end

        case (state_q)
            ST_ARM: begin
                if (crossing) begin
                    cnt_d   = '0;
                    xcnt_d  = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (accepted) begin
                    if (last_cross) begin
                        divisor_d = {1'b0, cnt_q} + DIV_W'(1);
                        rem_d     = DIV_W'(PERIODS);
                        quo_d     = '0;
                        step_d    = '0;
                        state_d   = ST_DIVIDE;
                    end else if (cnt_full) begin
                        no_signal_d = 1'b1;
                        armed_d     = 1'b0;
                        state_d     = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (crossing) begin
                            xcnt_d = xcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_DIVIDE: begin
                if (!rem_sub[DIV_W]) begin
                    rem_d = rem_sub[DIV_W-1:0];
                    quo_d = {quo_q[PHASE_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[DIV_W-1:0];
                    quo_d = {quo_q[PHASE_W-2:0], 1'b0};
                end
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(PHASE_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                phi_d       = quo_q;
                est_valid_d = 1'b1;
                no_signal_d = 1'b0;
                state_d     = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_ARM;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            xcnt_q      <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            phi_q       <= '0;
            est_valid_q <= 1'b0;
            no_signal_q <= 1'b0;
        end else if (clken) begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            xcnt_q      <= xcnt_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            phi_q       <= phi_d;
            est_valid_q <= est_valid_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign bus.phi_est_o = phi_q;
    assign bus.est_valid = est_valid_q;
    assign bus.busy      = (state_q == ST_DIVIDE);
    assign bus.no_signal = no_signal_q;
endmodule
